seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned restoring divider that sequences a single shared WIDTH-bit subtractor, one quotient bit per clock. Sits beside the arithmetic unit as its divide path: accepts a dividend/divisor pair on a start pulse, runs the iterations, and presents quotient and remainder with a one-cycle done strobe.

## Interface
- WIDTH, 4, operand/quotient/remainder width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, sampled with start
- divisor  input  WIDTH  unsigned divisor, sampled with start
- busy  output  1  high in CALC and DONE
- done  output  1  one-cycle pulse, results valid
- quotient  output  WIDTH  result, held until next accepted start
- remainder  output  WIDTH  result, held until next accepted start
- div_by_zero  output  1  divisor was 0 for the held result

Reset: one clock (clk), asynchronous active-low reset (rst_n); all outputs and all state registers clear to 0 on assertion, FSM to IDLE.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE: start=1 latches divisor into D, dividend into Q, clears R, count=WIDTH, clears div_by_zero; next state CALC (see Configuration for divisor=0).
- CALC, each cycle: shifted = {R[WIDTH-2:0], Q[WIDTH-1]}; subtractor computes shifted − D as WIDTH+1 result whose MSB is carry-out (1 = no borrow, shifted ≥ D).
  - carry=1: R ← difference[WIDTH-1:0], Q ← {Q[WIDTH-2:0],1}.
  - carry=0: R ← shifted, Q ← {Q[WIDTH-2:0],0}.
  - count decrements; at count=1 the update completes and next state is DONE.
- Partial remainder never exceeds WIDTH bits: before each shift R < 2^(WIDTH-1).
- DONE: done=1, quotient=Q, remainder=R; next state IDLE unconditionally.
- start in CALC or DONE: ignored, no queuing.
- quotient/remainder/div_by_zero registered; change only on the DONE-entry edge.
- rst_n asserted mid-operation: immediate abort, outputs to 0, no done pulse.

## Timing
- start sampled at edge E0 → CALC from E0; WIDTH CALC cycles; done high in the cycle after edge E0+WIDTH; total latency WIDTH+1 cycles start→done.
- Earliest next accepted start: the cycle after done (back in IDLE).
- busy rises the cycle after the start edge, falls with done.
- Throughput: one division per WIDTH+2 cycles when start is held high.

## Configuration
- DIV_ZERO_CHECK_EN defined: divisor=0 at start skips CALC, goes IDLE→DONE directly (done one cycle after start), quotient=all ones, remainder=dividend, div_by_zero=1.
- Undefined: no check; divisor=0 runs all WIDTH iterations, naturally producing quotient=all ones, remainder=dividend; div_by_zero tied 0; latency WIDTH+1.

## Structure
- Package div_pkg: state enum type (IDLE, CALC, DONE), default width constant DIV_WIDTH=4.
- One sub-module: sub_nbits (parameter WIDTH; inputs a, b; output s[WIDTH:0] with s[WIDTH]=carry-out, 1 when a ≥ b); single instance shared across all iterations.
- Counter, R/Q/D registers and FSM stay in the top module.

## Test plan
- WIDTH=4, 13/3 → done 5 cycles after start, quotient=0100, remainder=0001, div_by_zero=0.
- 15/15 → quotient=0001, remainder=0000; 7/9 → quotient=0000, remainder=0111; 8/1 → quotient=1000, remainder=0000.
- 12/0 with DIV_ZERO_CHECK_EN → done 1 cycle after start, quotient=1111, remainder=1100, div_by_zero=1; without macro → same values, done after 5 cycles, div_by_zero=0.
- start pulsed with 9/2 during busy of 13/3 → first result 0100/0001 only; no second done; outputs held.
- rst_n low 2 cycles into CALC → outputs 0 immediately, no done; subsequent 14/4 → 0011/0010.
- start held high continuously with fixed operands → done pulses every 6 cycles, busy low exactly one cycle between runs.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DIV_WIDTH = 4;

endpackage

// File: rtl/sub_nbits.sv
// WIDTH-bit subtractor; s[WIDTH] is carry-out, set when a >= b.
module sub_nbits #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   s
);

    assign s = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock on a shared subtractor.
// DIV_ZERO_CHECK_EN: divisor 0 skips the iterations and flags div_by_zero.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    // R < 2^(WIDTH-1) before every shift, so its top bit is never stored
    logic [WIDTH-2:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH:0]   sub_s;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;

    assign shifted = {r_q, q_q[WIDTH-1]};

    sub_nbits #(.WIDTH(WIDTH)) u_sub (
        .a(shifted),
        .b(d_q),
        .s(sub_s)
    );

    assign r_nx = sub_s[WIDTH] ? sub_s[WIDTH-1:0] : shifted;
    assign q_nx = {q_q[WIDTH-2:0], sub_s[WIDTH]};

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    cnt_d   = CW'(WIDTH);
                    dbz_d   = 1'b0;
                    state_d = CALC;
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                r_d   = r_nx[WIDTH-2:0];
                q_d   = q_nx;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = q_nx;
                    rem_d   = r_nx;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: arithmetic reference model plus directed cases.
module tb_seq_divider;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;
`ifdef DIV_ZERO_CHECK_EN
    localparam int ZLAT = 1;
    localparam int ZDBZ = 1;
`else
    localparam int ZLAT = W + 1;
    localparam int ZDBZ = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: cycles-to-done counter and arithmetic results
    int m_busy = 0, m_done = 0, m_cnt = 0;
    int m_quo = 0, m_rem = 0, m_dbz = 0;
    int p_q = 0, p_r = 0, p_z = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_cnt = 0;
            m_quo = 0; m_rem = 0; m_dbz = 0;
        end
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), m_done);
        chk("quotient", int'(quotient), m_quo);
        chk("remainder", int'(remainder), m_rem);
        chk("div_by_zero", int'(div_by_zero), m_dbz);
        if (rst_n) begin
            if (m_done != 0) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_busy != 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1;
                    m_quo = p_q; m_rem = p_r; m_dbz = p_z;
                end
            end else if (start) begin
                if (divisor == 0) begin
                    p_q = MAXV;
                    p_r = int'(dividend);
                end else begin
                    p_q = int'(dividend) / int'(divisor);
                    p_r = int'(dividend) % int'(divisor);
                end
                p_z = 0;
                m_busy = 1;
                m_dbz = 0;
                m_cnt = W;
`ifdef DIV_ZERO_CHECK_EN
                if (divisor == 0) begin
                    p_z = 1;
                    m_cnt = 0;
                    m_done = 1;
                    m_quo = p_q; m_rem = p_r; m_dbz = 1;
                end
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input int a, input int b);
        tick();
        dividend = W'(a);
        divisor  = W'(b);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run(input int a, input int b, input int eq,
                       input int er, input int ez, input int lat);
        int n;
        issue(a, b);
        wait_done(n);
        chk("latency", n, lat);
        chk("lit_quotient", int'(quotient), eq);
        chk("lit_remainder", int'(remainder), er);
        chk("lit_dbz", int'(div_by_zero), ez);
    endtask

    initial begin
        int n, ndone, last, cyc;
        rst_n = 1'b0;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", int'(busy), 0);
        chk("rst_quotient", int'(quotient), 0);
        rst_n = 1'b1;

        run(13, 3, 4, 1, 0, W + 1);
        run(15, 15, 1, 0, 0, W + 1);
        run(7, 9, 0, 7, 0, W + 1);
        run(8, 1, 8, 0, 0, W + 1);
        run(12, 0, 15, 12, ZDBZ, ZLAT);

        // start during busy is dropped
        issue(13, 3);
        tick();
        dividend = 4'd9;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        wait_done(n);
        chk("busy_ign_lat", n, W - 1);
        chk("busy_ign_q", int'(quotient), 4);
        chk("busy_ign_r", int'(remainder), 1);
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("busy_ign_ndone", ndone, 0);
        chk("busy_ign_hold", int'(quotient), 4);

        // reset two cycles into CALC
        issue(13, 3);
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_quotient", int'(quotient), 0);
        chk("abort_remainder", int'(remainder), 0);
        tick();
        rst_n = 1'b1;
        run(14, 4, 3, 2, 0, W + 1);

        // start held high: fixed cadence
        tick();
        dividend = 4'd7;
        divisor  = 4'd2;
        start    = 1'b1;
        ndone = 0;
        last = -1;
        for (cyc = 1; cyc <= 26; cyc++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (last >= 0) chk("period", cyc - last, W + 2);
                last = cyc;
            end
        end
        chk("held_ndone", ndone, 4);
        chk("held_q", int'(quotient), 3);
        start = 1'b0;
        repeat (10) tick();

        // random traffic, occasional reset
        for (int i = 0; i < 600; i++) begin
            tick();
            rst_n    = ($urandom_range(0, 99) != 0);
            start    = ($urandom_range(0, 2) == 0);
            dividend = W'($urandom_range(0, MAXV));
            divisor  = ($urandom_range(0, 7) == 0) ? '0
                     : W'($urandom_range(0, MAXV));
        end
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        repeat (10) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
